sqrt2_sched: RTL and testbench

// Round-robin scheduler that shares one sqrt2 float16 core between N requesters.

---
 rtl/sqrt2_sched_if.sv | 26 ++
 rtl/sqrt2_sched.sv | 138 +++++++++++++
 tb/tb_sqrt2_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt2_sched_if.sv
// Requester/response handshake bundle between the sqrt2 scheduler and its N_REQ clients.
// The master side is the requesters plus the response sink; the slave side is the scheduler.
interface sqrt2_sched_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [16*N_REQ-1:0] req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [15:0]         rsp_data;
    logic [3:0]          rsp_flags;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
    );
endinterface

// File: rtl/sqrt2_sched.sv
// Round-robin scheduler sharing one sqrt2 float16 core among N_REQ requesters,
// with a per-job watchdog and an ENABLE-low flush gap between jobs.
module sqrt2_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GAP     = 2
) (
    input  logic                clk,
    input  logic                rst,
    sqrt2_sched_if.slave        sched,
    inout  wire  [15:0]         sq_data,
    output logic                sq_enable,
    input  logic                sq_result,
    input  logic                sq_is_nan,
    input  logic                sq_is_pinf,
    input  logic                sq_is_ninf
);
    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned WW   = $clog2(TIMEOUT);
    localparam int unsigned GW   = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP - 1);
    localparam logic [ID_W-1:0] ID_LAST   = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        RESP,
        FLUSH
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cur_id;
    logic [15:0]     op;
    logic [WW-1:0]   wait_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [15:0]     rsp_data_q;
    logic [3:0]      rsp_flags_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            found;
    logic [ID_W-1:0] win;
    logic            bus_oe;
    logic [N_REQ-1:0] ready;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (!found && sched.req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (!rst && state == IDLE && found)
            ready[win] = 1'b1;
    end

    assign sched.req_ready = ready;
    assign sched.rsp_valid = (state == RESP);
    assign sched.rsp_id    = rsp_id_q;
    assign sched.rsp_data  = rsp_data_q;
    assign sched.rsp_flags = rsp_flags_q;

    // The core holds its result as long as ENABLE stays high, so RESP keeps it asserted.
    assign sq_enable = (state == LOAD) || (state == WAIT) || (state == RESP);
    assign bus_oe    = (state == LOAD);
    assign sq_data   = bus_oe ? op : 'z;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (found) state_nxt = LOAD;
            LOAD:  state_nxt = WAIT;
            WAIT:  if (sq_result || wait_cnt == WAIT_LAST) state_nxt = RESP;
            RESP:  if (sched.rsp_ready) state_nxt = FLUSH;
            FLUSH: if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cur_id      <= '0;
            op          <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_id_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        op     <= sched.req_data[16*int'(win) +: 16];
                        cur_id <= win;
                    end
                end
                LOAD: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A result arriving on the watchdog's last cycle still counts as a result.
                    if (sq_result) begin
                        rsp_data_q  <= sq_data;
                        rsp_flags_q <= {1'b0, sq_is_nan, sq_is_pinf, sq_is_ninf};
                        rsp_id_q    <= cur_id;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_data_q  <= 16'h7E00;
                        rsp_flags_q <= 4'b1000;
                        rsp_id_q    <= cur_id;
                    end
                end
                RESP: begin
                    if (sched.rsp_ready) begin
                        ptr     <= (cur_id == ID_LAST) ? '0 : cur_id + 1'b1;
                        gap_cnt <= '0;
                    end
                end
                FLUSH: gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt2_sched.sv
// Directed bench for sqrt2_sched with a behavioural sqrt2 core model on the shared bus.
module tb_sqrt2_sched;
    localparam int unsigned N_REQ    = 4;
    localparam int unsigned TIMEOUT  = 8;
    localparam int unsigned GAP      = 2;
    localparam int unsigned CORE_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire  [15:0] sq_data;
    logic sq_enable;
    logic core_res = 1'b0, core_nan = 1'b0, core_pinf = 1'b0, core_ninf = 1'b0;
    logic core_drv = 1'b0, core_hang = 1'b0, en_d = 1'b0;
    logic [15:0] core_val = '0, core_op = '0;
    int unsigned core_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;
    int oe_bad = 0;
    int contention = 0;
    logic en_prev = 1'b0;

    always #5 clk = ~clk;

    sqrt2_sched_if #(.N_REQ(N_REQ)) sif();

    sqrt2_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk),
        .rst(rst),
        .sched(sif),
        .sq_data(sq_data),
        .sq_enable(sq_enable),
        .sq_result(core_res),
        .sq_is_nan(core_nan),
        .sq_is_pinf(core_pinf),
        .sq_is_ninf(core_ninf)
    );

    assign sq_data = core_drv ? core_val : 'z;

    // Core model: samples the operand on the first ENABLE cycle, answers CORE_LAT cycles later.
    always @(posedge clk) begin
        en_d <= sq_enable;
        if (rst || !sq_enable) begin
            core_drv <= 1'b0; core_res <= 1'b0;
            core_nan <= 1'b0; core_pinf <= 1'b0; core_ninf <= 1'b0;
            core_cnt <= 0;
        end else if (!en_d) begin
            core_op  <= sq_data;
            core_cnt <= 1;
        end else if (!core_drv && !core_hang) begin
            if (core_cnt == CORE_LAT) begin
                core_drv <= 1'b1;
                core_res <= 1'b1;
                case (core_op)
                    16'h4400: core_val <= 16'h4000;
                    16'h3C00: core_val <= 16'h3C00;
                    16'h7C00: begin core_val <= 16'h7C00; core_pinf <= 1'b1; end
                    default:  begin core_val <= 16'h7E00; core_nan  <= 1'b1; end
                endcase
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    // The scheduler may drive the bus only in the single cycle where ENABLE first rises.
    always @(negedge clk) begin
        en_prev <= sq_enable;
        if (dut.bus_oe !== (sq_enable && !en_prev)) oe_bad <= oe_bad + 1;
        if (dut.bus_oe && core_drv) contention <= contention + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic submit(input int id, input logic [15:0] operand);
        int n = 0;
        sif.req_data[16*id +: 16] = operand;
        sif.req_valid[id] = 1'b1;
        #1;
        while (!sif.req_ready[id] && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!sif.req_ready[id]) check("ready_wait_timeout", 0, 1);
        @(negedge clk);
        sif.req_valid[id] = 1'b0;
        #1;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!sif.rsp_valid && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!sif.rsp_valid) check("rsp_wait_timeout", 0, 1);
    endtask

    task automatic check_rsp(input string tag, input int id, input logic [15:0] d, input logic [3:0] f);
        check({tag, "_id"}, 32'(sif.rsp_id), 32'(id));
        check({tag, "_data"}, 32'(sif.rsp_data), 32'(d));
        check({tag, "_flags"}, 32'(sif.rsp_flags), 32'(f));
    endtask

    // Counts ENABLE-low, no-ready cycles after an accept until a grant appears.
    task automatic count_flush(output int n);
        int b = 0;
        n = 0;
        @(negedge clk); #1;
        while (sif.req_ready == '0 && b < 50) begin
            if (!sq_enable) n++;
            b++;
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int n;
        sif.req_valid = '0;
        sif.req_data  = '0;
        sif.rsp_ready = 1'b1;

        // Reset state, with all requesters asserting valid.
        sif.req_valid = 4'b1111;
        #1;
        check("rst_enable", 32'(sq_enable), 0);
        check("rst_ready", 32'(sif.req_ready), 0);
        check("rst_rsp_valid", 32'(sif.rsp_valid), 0);
        check("rst_bus_oe", 32'(dut.bus_oe), 0);
        check_rsp("rst", 0, 16'h0000, 4'b0000);
        sif.req_valid = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single job: sqrt(4.0) = 2.0
        submit(0, 16'h4400);
        wait_rsp();
        check_rsp("single", 0, 16'h4000, 4'b0000);
        @(negedge clk); #1;
        check("single_rsp_drop", 32'(sif.rsp_valid), 0);

        // Round robin from a fresh pointer
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) sif.req_data[16*i +: 16] = 16'h3C00;
        sif.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp();
            if (k == 4) sif.req_valid = '0;
            check_rsp($sformatf("rr%0d", k), k % 4, 16'h3C00, 4'b0000);
            @(negedge clk); #1;
        end

        // Special operands
        submit(2, 16'hC400);
        wait_rsp();
        check_rsp("neg", 2, 16'h7E00, 4'b0100);
        @(negedge clk);
        submit(1, 16'h7C00);
        wait_rsp();
        check_rsp("pinf", 1, 16'h7C00, 4'b0010);
        @(negedge clk);

        // Watchdog: core never answers
        core_hang = 1'b1;
        submit(3, 16'h3C00);
        n = 0;
        while (!sif.rsp_valid && sq_enable && n < 500) begin
            n++; @(negedge clk); #1;
        end
        check("timeout_enable_cycles", 32'(n), 32'(TIMEOUT + 1));
        check_rsp("timeout", 3, 16'h7E00, 4'b1000);
        core_hang = 1'b0;
        sif.req_data[15:0] = 16'h4400;
        sif.req_valid[0] = 1'b1;
        count_flush(n);
        check("timeout_gap", 32'(n), 32'(GAP));
        check("timeout_next_grant", 32'(sif.req_ready), 32'h1);
        submit(0, 16'h4400);
        wait_rsp();
        check_rsp("after_timeout", 0, 16'h4000, 4'b0000);
        @(negedge clk);

        // Response back-pressure with another requester waiting
        sif.rsp_ready = 1'b0;
        submit(1, 16'h4400);
        sif.req_data[63:48] = 16'h4400;
        sif.req_valid[3] = 1'b1;
        wait_rsp();
        for (int c = 0; c < 10; c++) begin
            check("stall_valid", 32'(sif.rsp_valid), 1);
            check("stall_enable", 32'(sq_enable), 1);
            check("stall_ready", 32'(sif.req_ready), 0);
            check_rsp("stall", 1, 16'h4000, 4'b0000);
            @(negedge clk); #1;
        end
        sif.rsp_ready = 1'b1;
        count_flush(n);
        check("stall_gap", 32'(n), 32'(GAP));
        check("stall_next_grant", 32'(sif.req_ready), 32'h8);
        submit(3, 16'h4400);
        wait_rsp();
        check_rsp("after_stall", 3, 16'h4000, 4'b0000);
        @(negedge clk);

        // Reset in the middle of WAIT drops the job
        submit(2, 16'h4400);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_enable", 32'(sq_enable), 0);
        check("midrst_bus_oe", 32'(dut.bus_oe), 0);
        check("midrst_rsp_valid", 32'(sif.rsp_valid), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            if (sif.rsp_valid || sq_enable) n++;
        end
        check("midrst_quiet", 32'(n), 0);

        check("bus_oe_only_in_load", 32'(oe_bad), 0);
        check("bus_contention", 32'(contention), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
